// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of the 5-stage 16-bit pipeline. Owns the PC, issues
// requests to a variable-latency instruction memory, holds one fetched
// instruction in a single-entry buffer while downstream stalls, squashes on an
// EX-stage redirect and stops requesting once a HALT has been captured.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   stall                  downstream cannot accept the buffered instruction
//   redirect_valid/_pc     taken branch/jump from EX; overrides everything but rst
//   imem_req/imem_addr     fetch request and address (address = pc)
//   imem_rdata/imem_ready  returned instruction word and its valid strobe
//   valid_out, instr_out   buffered instruction toward IF/ID (NOP when invalid)
//   curr_pc_out            PC of instr_out
//   next_pc_out            curr_pc_out + 2
//   halted                 fetch stopped after a HALT was captured
//
// FSM states
//   state   | meaning
//   FETCH   | requesting instructions whenever the buffer can take one
//   HALTED  | HALT captured; no further requests until a redirect
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] NOP_INSTR   = 16'h0800,
    parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ready,
    output logic        valid_out,
    output logic [15:0] instr_out,
    output logic [15:0] curr_pc_out,
    output logic [15:0] next_pc_out,
    output logic        halted
);

    typedef enum logic {FETCH = 1'b0, HALTED = 1'b1} fetchState_t;

    fetchState_t stateQ;
    fetchState_t stateNext;

    logic [15:0] pc;
    logic [15:0] pcQ;
    logic [15:0] instrQ;
    logic        validQ;

    logic        capture;
    logic        consume;
    logic        isHalt;

    // A request is only made when the buffer is free or is draining this cycle,
    // so a capture never overwrites an instruction that has not been consumed.
    assign imem_req  = !rst && (stateQ == FETCH) && !redirect_valid && (!validQ || !stall);
    assign imem_addr = pc;
    assign capture   = imem_req && imem_ready;
    assign consume   = validQ && !stall && !redirect_valid;
    assign isHalt    = (imem_rdata[15:11] == HALT_OPCODE);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= FETCH;
        end else begin
            stateQ <= stateNext;
        end
    end

    // FSM next-state logic
    always_comb begin
        stateNext = stateQ;
        if (redirect_valid) begin
            stateNext = FETCH;
        end else if (capture && isHalt) begin
            stateNext = HALTED;
        end
    end

    // FSM outputs
    always_comb begin
        halted = 1'b0;
        if (stateQ == HALTED) begin
            halted = 1'b1;
        end
    end

    // PC and one-entry instruction buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            pcQ    <= RESET_PC;
            instrQ <= NOP_INSTR;
            validQ <= 1'b0;
        end else if (redirect_valid) begin
            // Buffered instruction is squashed; its data is left stale but invisible.
            pc     <= redirect_pc;
            validQ <= 1'b0;
        end else if (capture) begin
            instrQ <= imem_rdata;
            pcQ    <= pc;
            validQ <= 1'b1;
            pc     <= pc + 16'd2;
        end else if (consume) begin
            validQ <= 1'b0;
        end
    end

    assign valid_out   = validQ;
    assign instr_out   = validQ ? instrQ : NOP_INSTR;
    assign curr_pc_out = pcQ;
    assign next_pc_out = pcQ + 16'd2;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic        valid_out;
    logic [15:0] instr_out;
    logic [15:0] curr_pc_out;
    logic [15:0] next_pc_out;
    logic        halted;

    int vecs = 0;
    int errs = 0;

    logic        haltEn;
    logic [15:0] haltAt;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_ready     (imem_ready),
        .valid_out      (valid_out),
        .instr_out      (instr_out),
        .curr_pc_out    (curr_pc_out),
        .next_pc_out    (next_pc_out),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: opcode 00010 tagged with the low address bits, or HALT at haltAt.
    function automatic logic [15:0] word(input logic [15:0] a);
        return {5'b00010, a[10:0]};
    endfunction

    assign imem_rdata = (haltEn && imem_addr == haltAt) ? 16'h0000 : word(imem_addr);

    // Inputs change 3 time units after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; imem_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 16'h1234;
        tick(); tick();
        #1;
        vecs++;
        if ({imem_req, valid_out, instr_out, curr_pc_out, next_pc_out, halted} !== {1'b0, 1'b0, 16'h0800, 16'h0000, 16'h0002, 1'b0}) begin
            errs++;
            $display("FAIL reset_outputs: req=%b v=%b instr=%h curr=%h next=%h halted=%b, want 0 0 0800 0000 0002 0",
                     imem_req, valid_out, instr_out, curr_pc_out, next_pc_out, halted);
        end
    endtask

    task automatic test_stream();
        rst = 1'b0; redirect_valid = 1'b0;
        #1;
        vecs++;
        if ({imem_req, imem_addr, valid_out} !== {1'b1, 16'h0000, 1'b0}) begin
            errs++;
            $display("FAIL stream_first_req: req=%b addr=%h v=%b, want 1 0000 0", imem_req, imem_addr, valid_out);
        end
        for (int i = 0; i < 2; i++) begin
            tick(); #1;
            vecs++;
            if ({valid_out, curr_pc_out, next_pc_out, instr_out} !== {1'b1, 16'(2*i), 16'(2*i+2), word(16'(2*i))}) begin
                errs++;
                $display("FAIL stream_%0d: v=%b curr=%h next=%h instr=%h, want 1 %h %h %h", i,
                         valid_out, curr_pc_out, next_pc_out, instr_out, 16'(2*i), 16'(2*i+2), word(16'(2*i)));
            end
        end
    endtask

    task automatic test_wait();
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            vecs++;
            if ({imem_req, imem_addr, valid_out, instr_out} !== {1'b1, 16'h0004, 1'b0, 16'h0800}) begin
                errs++;
                $display("FAIL wait_%0d: req=%b addr=%h v=%b instr=%h, want 1 0004 0 0800", i,
                         imem_req, imem_addr, valid_out, instr_out);
            end
        end
        imem_ready = 1'b1;
        tick(); #1;
        vecs++;
        if ({valid_out, curr_pc_out, instr_out, imem_addr} !== {1'b1, 16'h0004, word(16'h0004), 16'h0006}) begin
            errs++;
            $display("FAIL wait_release: v=%b curr=%h instr=%h addr=%h, want 1 0004 %h 0006",
                     valid_out, curr_pc_out, instr_out, imem_addr, word(16'h0004));
        end
    endtask

    task automatic test_stall();
        tick();
        stall = 1'b1;
        #1;
        vecs++;
        if ({imem_req, curr_pc_out} !== {1'b0, 16'h0006}) begin
            errs++;
            $display("FAIL stall_enter: req=%b curr=%h, want 0 0006", imem_req, curr_pc_out);
        end
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            vecs++;
            if ({valid_out, curr_pc_out, instr_out, imem_req, imem_addr} !== {1'b1, 16'h0006, word(16'h0006), 1'b0, 16'h0008}) begin
                errs++;
                $display("FAIL stall_hold_%0d: v=%b curr=%h instr=%h req=%b addr=%h, want 1 0006 %h 0 0008", i,
                         valid_out, curr_pc_out, instr_out, imem_req, imem_addr, word(16'h0006));
            end
        end
        stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(); #1;
            vecs++;
            if ({valid_out, curr_pc_out} !== {1'b1, 16'(8 + 2*i)}) begin
                errs++;
                $display("FAIL stall_release_%0d: v=%b curr=%h, want 1 %h", i, valid_out, curr_pc_out, 16'(8 + 2*i));
            end
        end
    endtask

    task automatic test_redirect();
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0100;
        #1;
        vecs++;
        if (imem_req !== 1'b0) begin
            errs++;
            $display("FAIL redirect_no_req: req=%b, want 0", imem_req);
        end
        tick();
        redirect_valid = 1'b0;
        #1;
        vecs++;
        if ({valid_out, instr_out, imem_req, imem_addr} !== {1'b0, 16'h0800, 1'b1, 16'h0100}) begin
            errs++;
            $display("FAIL redirect_squash: v=%b instr=%h req=%b addr=%h, want 0 0800 1 0100",
                     valid_out, instr_out, imem_req, imem_addr);
        end
        stall = 1'b0;
        tick(); #1;
        vecs++;
        if ({valid_out, curr_pc_out} !== {1'b1, 16'h0100}) begin
            errs++;
            $display("FAIL redirect_target: v=%b curr=%h, want 1 0100", valid_out, curr_pc_out);
        end
        redirect_valid = 1'b1; redirect_pc = 16'h0101;
        tick();
        redirect_valid = 1'b0;
        #1;
        vecs++;
        if ({imem_addr, valid_out} !== {16'h0101, 1'b0}) begin
            errs++;
            $display("FAIL redirect_odd: addr=%h v=%b, want 0101 0", imem_addr, valid_out);
        end
    endtask

    task automatic test_halt();
        haltEn = 1'b1; haltAt = 16'h0010;
        redirect_valid = 1'b1; redirect_pc = 16'h0010;
        tick();
        redirect_valid = 1'b0;
        tick(); #1;
        vecs++;
        if ({valid_out, instr_out, curr_pc_out, halted, imem_req} !== {1'b1, 16'h0000, 16'h0010, 1'b1, 1'b0}) begin
            errs++;
            $display("FAIL halt_emit: v=%b instr=%h curr=%h halted=%b req=%b, want 1 0000 0010 1 0",
                     valid_out, instr_out, curr_pc_out, halted, imem_req);
        end
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            vecs++;
            if ({valid_out, instr_out, halted, imem_req} !== {1'b0, 16'h0800, 1'b1, 1'b0}) begin
                errs++;
                $display("FAIL halt_idle_%0d: v=%b instr=%h halted=%b req=%b, want 0 0800 1 0", i,
                         valid_out, instr_out, halted, imem_req);
            end
        end
        redirect_valid = 1'b1; redirect_pc = 16'h0020;
        tick();
        redirect_valid = 1'b0;
        #1;
        vecs++;
        if ({halted, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0020}) begin
            errs++;
            $display("FAIL halt_resume: halted=%b req=%b addr=%h, want 0 1 0020", halted, imem_req, imem_addr);
        end
        tick(); #1;
        vecs++;
        if ({valid_out, curr_pc_out, instr_out} !== {1'b1, 16'h0020, word(16'h0020)}) begin
            errs++;
            $display("FAIL halt_resume_fetch: v=%b curr=%h instr=%h, want 1 0020 %h",
                     valid_out, curr_pc_out, instr_out, word(16'h0020));
        end
        haltEn = 1'b0;
    endtask

    task automatic test_wrap_reset();
        redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        tick();
        redirect_valid = 1'b0;
        tick(); #1;
        vecs++;
        if ({valid_out, curr_pc_out, next_pc_out, imem_addr} !== {1'b1, 16'hFFFE, 16'h0000, 16'h0000}) begin
            errs++;
            $display("FAIL wrap_fffe: v=%b curr=%h next=%h addr=%h, want 1 fffe 0000 0000",
                     valid_out, curr_pc_out, next_pc_out, imem_addr);
        end
        tick(); #1;
        vecs++;
        if ({valid_out, curr_pc_out, next_pc_out} !== {1'b1, 16'h0000, 16'h0002}) begin
            errs++;
            $display("FAIL wrap_0000: v=%b curr=%h next=%h, want 1 0000 0002", valid_out, curr_pc_out, next_pc_out);
        end
        imem_ready = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        vecs++;
        if ({imem_req, valid_out} !== {1'b0, 1'b0}) begin
            errs++;
            $display("FAIL rst_mid_wait_req: req=%b v=%b, want 0 0", imem_req, valid_out);
        end
        tick();
        rst = 1'b0; imem_ready = 1'b1;
        #1;
        vecs++;
        if ({valid_out, instr_out, curr_pc_out, next_pc_out, halted, imem_req, imem_addr} !==
            {1'b0, 16'h0800, 16'h0000, 16'h0002, 1'b0, 1'b1, 16'h0000}) begin
            errs++;
            $display("FAIL rst_mid_wait_state: v=%b instr=%h curr=%h next=%h halted=%b req=%b addr=%h, want 0 0800 0000 0002 0 1 0000",
                     valid_out, instr_out, curr_pc_out, next_pc_out, halted, imem_req, imem_addr);
        end
    endtask

    initial begin
        haltEn = 1'b0; haltAt = 16'h0000;
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000; imem_ready = 1'b1;
        test_reset();
        test_stream();
        test_wait();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
